cache_fill_fsm_param: RTL and testbench
=======================================

Name: cache_fill_fsm_param

Overview:
Parametrised cache-miss handler, the successor to the fixed 8-word fill FSM. On a miss it optionally writes back a dirty victim line, then refills the line from memory. Memory uses a request/ready handshake with pipelined, in-order read returns, capped at MAX_OUT outstanding reads. It sits between the cache tag/data arrays and the memory arbiter; fsm_busy is the pipeline stall.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, word width (multiple of 8)
WORDS, 8, words per line (power of two, >=2)
MAX_OUT, 4, max outstanding memory reads (1..WORDS)
WB_EN, 1, 1 = dirty-victim writeback enabled; 0 = fill only
Derived: IDX_W=log2(WORDS); BO=log2(DATA_W/8); LINE_LSB=IDX_W+BO

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
miss_detected  in  1  tag logic reports a miss (level)
miss_address  in  ADDR_W  missing address
victim_dirty  in  1  victim line is dirty
victim_address  in  ADDR_W  any byte address within the victim line
mem_req_valid  out  1  memory request valid
mem_req_write  out  1  1 = write, 0 = read
mem_req_addr  out  ADDR_W  request byte address
mem_req_wdata  out  DATA_W  write data
mem_req_ready  in  1  memory accepts the request this cycle
mem_rdata_valid  in  1  read data returning
mem_rdata  in  DATA_W  returned data
cache_rd_idx  out  IDX_W  word index to read from the data array (combinational read)
cache_rd_data  in  DATA_W  data-array read data for cache_rd_idx
write_data_array  out  1  data-array write enable
cache_array_addr  out  IDX_W  data-array word index
cache_array_data  out  DATA_W  data-array write data
write_tag_array  out  1  tag write pulse
write_valid_bit  out  1  valid-bit write pulse
clear_dirty_bit  out  1  dirty-bit clear pulse
fsm_busy  out  1  miss in progress
fill_done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, WB, FILL. Counters: wb_cnt and iss_cnt (IDX_W+1 bits each); ret_cnt (IDX_W+1); out_cnt (log2(MAX_OUT)+1).
- Reset (async, rst_n=0): state=IDLE, all counters 0, address latches 0. All outputs 0, including data and address buses. This holds mid-operation: the in-flight miss is abandoned and no tag/valid write occurs.
- IDLE: fsm_busy=0. When miss_detected=1, latch the line base of miss_address and of victim_address (low LINE_LSB bits zeroed).
  - Go to WB if WB_EN=1 and victim_dirty=1; otherwise go to FILL.
  - mem_rdata_valid in IDLE is ignored.
- fsm_busy=1 in WB and FILL, including the final cycle. miss_detected is ignored while busy.
- WB:
  - mem_req_valid=1, mem_req_write=1.
  - mem_req_addr = victim_base + (wb_cnt << BO); cache_rd_idx = wb_cnt[IDX_W-1:0]; mem_req_wdata = cache_rd_data.
  - wb_cnt increments only on valid&ready. Request fields stay stable while ready=0.
  - After the WORDS-th acceptance, go to FILL next cycle.
- FILL, requests:
  - mem_req_valid = (iss_cnt<WORDS) && (out_cnt<MAX_OUT); mem_req_write=0.
  - mem_req_addr = miss_base + (iss_cnt << BO).
  - iss_cnt increments on acceptance.
- FILL, returns: each mem_rdata_valid asserts write_data_array the same cycle, with cache_array_addr=ret_cnt[IDX_W-1:0] and cache_array_data=mem_rdata. ret_cnt then increments.
- out_cnt: +1 on read acceptance, -1 on return; both in the same cycle means no change. A return may arrive in the same cycle as its acceptance, and still counts as zero-latency.
- Completion: on the cycle the WORDS-th return is written, pulse write_tag_array, write_valid_bit, clear_dirty_bit and fill_done for one cycle. Next state is IDLE with counters cleared.
- When not writing, write_data_array=0 and cache_array_addr/cache_array_data=0. Address arithmetic wraps modulo 2^ADDR_W.
- Minimum latency (WB_EN=0, ready always 1, zero-latency returns): miss seen in IDLE at cycle 0; fill_done at cycle WORDS.

Test Plan:
1. Defaults; clean miss at 0x1234; ready=1; each return 2 cycles after acceptance -> read addresses 0x1230,0x1232,...,0x123E; array idx 0..7 written with the returned data; single tag/valid/fill_done pulse; exactly 8 reads issued.
2. Dirty miss: victim 0x5670, miss 0x9A00, array holding 0xA0..0xA7 -> 8 writes to 0x5670..0x567E carrying 0xA0..0xA7, then 8 reads from 0x9A00; clear_dirty_bit pulses once.
3. MAX_OUT=2, returns delayed 6 cycles -> mem_req_valid never high while 2 reads are outstanding; no lost or duplicated words.
4. mem_req_ready random 50% during WB and FILL -> addr/wdata stable while stalled; counts exactly 8+8.
5. Assert rst_n=0 after 3 returns -> outputs 0 immediately; no tag write. A new miss after reset fills the full line from word 0.
6. WORDS=4, DATA_W=32, WB_EN=0, miss 0x0000_FFF8 with ADDR_W=32 -> reads 0xFFF0,0xFFF4,0xFFF8,0xFFFC; a dirty victim is ignored (no writes issued).

Source files
------------

// File: rtl/cache_fill_fsm_param.sv
// Cache-miss handler: optional dirty-victim writeback, then a pipelined line refill.
// Reads are issued in order with a cap on outstanding requests.
module cache_fill_fsm_param #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 8,
  parameter int MAX_OUT = 4,
  parameter bit WB_EN   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_address,
  input  logic                     victim_dirty,
  input  logic [ADDR_W-1:0]        victim_address,
  output logic                     mem_req_valid,
  output logic                     mem_req_write,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [DATA_W-1:0]        mem_req_wdata,
  input  logic                     mem_req_ready,
  input  logic                     mem_rdata_valid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [$clog2(WORDS)-1:0] cache_rd_idx,
  input  logic [DATA_W-1:0]        cache_rd_data,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] cache_array_addr,
  output logic [DATA_W-1:0]        cache_array_data,
  output logic                     write_tag_array,
  output logic                     write_valid_bit,
  output logic                     clear_dirty_bit,
  output logic                     fsm_busy,
  output logic                     fill_done
);

  localparam int IDX_W    = $clog2(WORDS);
  localparam int BO       = $clog2(DATA_W / 8);
  localparam int LINE_LSB = IDX_W + BO;
  localparam int OUT_W    = $clog2(MAX_OUT) + 1;

  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(WORDS);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(WORDS - 1);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << LINE_LSB;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL
  } state_t;

  state_t state, state_n;

  logic [IDX_W:0]    wb_cnt, wb_n;
  logic [IDX_W:0]    iss_cnt, iss_n;
  logic [IDX_W:0]    ret_cnt, ret_n;
  logic [OUT_W-1:0]  out_cnt, out_n;
  logic [ADDR_W-1:0] miss_base, miss_n;
  logic [ADDR_W-1:0] vict_base, vict_n;
  logic              acc, ret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wb_cnt    <= '0;
      iss_cnt   <= '0;
      ret_cnt   <= '0;
      out_cnt   <= '0;
      miss_base <= '0;
      vict_base <= '0;
    end else begin
      state     <= state_n;
      wb_cnt    <= wb_n;
      iss_cnt   <= iss_n;
      ret_cnt   <= ret_n;
      out_cnt   <= out_n;
      miss_base <= miss_n;
      vict_base <= vict_n;
    end
  end

  always_comb begin
    state_n          = state;
    wb_n             = wb_cnt;
    iss_n            = iss_cnt;
    ret_n            = ret_cnt;
    out_n            = out_cnt;
    miss_n           = miss_base;
    vict_n           = vict_base;
    acc              = 1'b0;
    ret              = 1'b0;
    mem_req_valid    = 1'b0;
    mem_req_write    = 1'b0;
    mem_req_addr     = '0;
    mem_req_wdata    = '0;
    cache_rd_idx     = '0;
    write_data_array = 1'b0;
    cache_array_addr = '0;
    cache_array_data = '0;
    write_tag_array  = 1'b0;
    write_valid_bit  = 1'b0;
    clear_dirty_bit  = 1'b0;
    fsm_busy         = 1'b0;
    fill_done        = 1'b0;

    unique case (state)
      IDLE: begin
        if (miss_detected) begin
          miss_n  = miss_address & LINE_MASK;
          vict_n  = victim_address & LINE_MASK;
          state_n = (WB_EN && victim_dirty) ? WB : FILL;
        end
      end
      WB: begin
        fsm_busy      = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = vict_base + (ADDR_W'(wb_cnt) << BO);
        cache_rd_idx  = wb_cnt[IDX_W-1:0];
        mem_req_wdata = cache_rd_data;
        if (mem_req_ready) begin
          wb_n = wb_cnt + CNT_ONE;
          if (wb_cnt == CNT_LAST) state_n = FILL;
        end
      end
      FILL: begin
        fsm_busy      = 1'b1;
        mem_req_valid = (iss_cnt < CNT_FULL) && (out_cnt < OUT_MAX);
        mem_req_addr  = miss_base + (ADDR_W'(iss_cnt) << BO);
        acc           = mem_req_valid && mem_req_ready;
        ret           = mem_rdata_valid && (ret_cnt < CNT_FULL);
        if (acc) iss_n = iss_cnt + CNT_ONE;
        // accept and return together leave the outstanding count unchanged
        if (acc && !ret) out_n = out_cnt + OUT_ONE;
        else if (ret && !acc) out_n = out_cnt - OUT_ONE;
        if (ret) begin
          write_data_array = 1'b1;
          cache_array_addr = ret_cnt[IDX_W-1:0];
          cache_array_data = mem_rdata;
          ret_n            = ret_cnt + CNT_ONE;
        end
        if (ret && ret_cnt == CNT_LAST) begin
          write_tag_array = 1'b1;
          write_valid_bit = 1'b1;
          clear_dirty_bit = 1'b1;
          fill_done       = 1'b1;
          state_n         = IDLE;
          wb_n            = '0;
          iss_n           = '0;
          ret_n           = '0;
          out_n           = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm_param.sv
// Bench for cache_fill_fsm_param: two configurations driven by a randomised
// memory responder and checked against expected request/array-write lists.
module tb_cache_fill_fsm_param;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } aw_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] seed;
  int last_c0;

  int acc[2], rets[2], dones[2], tags[2], vbs[2], cds[2], bad[2], done_cyc[2];
  int dly[2];
  bit rnd[2], rdly[2];

  req_t  a_reqs[$], b_reqs[$];
  pend_t a_pend[$], b_pend[$];
  aw_t   a_aws[$], b_aws[$];

  // instance A: default configuration
  logic        a_miss, a_vd, a_rv, a_rw, a_rdy, a_dv, a_wda;
  logic        a_tag, a_vb, a_cd, a_busy, a_done;
  logic [15:0] a_maddr, a_vaddr, a_raddr, a_wdata, a_rdata, a_rdat, a_adata;
  logic [2:0]  a_ridx, a_aidx;
  logic [31:0] a_arr[8];
  logic        a_pv, a_pr, a_pw;
  logic [15:0] a_pa, a_pd;

  assign a_rdat = a_arr[a_ridx][15:0];

  cache_fill_fsm_param u_a (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(a_miss), .miss_address(a_maddr),
    .victim_dirty(a_vd), .victim_address(a_vaddr),
    .mem_req_valid(a_rv), .mem_req_write(a_rw),
    .mem_req_addr(a_raddr), .mem_req_wdata(a_wdata),
    .mem_req_ready(a_rdy), .mem_rdata_valid(a_dv), .mem_rdata(a_rdata),
    .cache_rd_idx(a_ridx), .cache_rd_data(a_rdat),
    .write_data_array(a_wda), .cache_array_addr(a_aidx),
    .cache_array_data(a_adata), .write_tag_array(a_tag),
    .write_valid_bit(a_vb), .clear_dirty_bit(a_cd),
    .fsm_busy(a_busy), .fill_done(a_done)
  );

  // instance B: wide, short line, fill only, two outstanding reads
  logic        b_miss, b_vd, b_rv, b_rw, b_rdy, b_dv, b_wda;
  logic        b_tag, b_vb, b_cd, b_busy, b_done;
  logic [31:0] b_maddr, b_vaddr, b_raddr, b_wdata, b_rdata, b_rdat, b_adata;
  logic [1:0]  b_ridx, b_aidx;
  logic        b_pv, b_pr;
  logic [31:0] b_pa;

  cache_fill_fsm_param #(
    .ADDR_W(32), .DATA_W(32), .WORDS(4), .MAX_OUT(2), .WB_EN(1'b0)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(b_miss), .miss_address(b_maddr),
    .victim_dirty(b_vd), .victim_address(b_vaddr),
    .mem_req_valid(b_rv), .mem_req_write(b_rw),
    .mem_req_addr(b_raddr), .mem_req_wdata(b_wdata),
    .mem_req_ready(b_rdy), .mem_rdata_valid(b_dv), .mem_rdata(b_rdata),
    .cache_rd_idx(b_ridx), .cache_rd_data(b_rdat),
    .write_data_array(b_wda), .cache_array_addr(b_aidx),
    .cache_array_data(b_adata), .write_tag_array(b_tag),
    .write_valid_bit(b_vb), .clear_dirty_bit(b_cd),
    .fsm_busy(b_busy), .fill_done(b_done)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory responder and monitor for A
  always @(negedge clk) begin
    pend_t p;
    req_t  r;
    aw_t   w;
    a_rdy = rnd[0] ? 1'($urandom_range(0, 1)) : 1'b1;
    if (a_rv && !a_rw && (acc[0] - rets[0]) >= 4) bad[0]++;
    if (a_rv && a_rdy) begin
      r.w = a_rw; r.addr = 32'(a_raddr); r.data = 32'(a_wdata);
      a_reqs.push_back(r);
      if (!a_rw) begin
        p.addr = 32'(a_raddr);
        p.due  = cyc + (rdly[0] ? int'($urandom_range(0, 4)) : dly[0]);
        a_pend.push_back(p);
        acc[0]++;
      end
    end
    if (a_pend.size() > 0 && a_pend[0].due <= cyc) begin
      a_dv = 1'b1;
      a_rdata = 16'(memf(a_pend[0].addr));
      void'(a_pend.pop_front());
      rets[0]++;
    end else begin
      a_dv = 1'b0;
      a_rdata = '0;
    end
    #1;
    if (a_wda) begin
      w.idx = int'(a_aidx); w.data = 32'(a_adata);
      a_aws.push_back(w);
    end
    if (a_done) begin
      dones[0]++;
      done_cyc[0] = cyc;
      if (!(a_wda && a_aidx == 3'd7 && a_busy)) bad[0]++;
    end
    tags[0] += int'(a_tag);
    vbs[0]  += int'(a_vb);
    cds[0]  += int'(a_cd);
    if (a_pv && !a_pr &&
        !(a_rv && a_rw == a_pw && a_raddr == a_pa && a_wdata == a_pd))
      bad[0]++;
    a_pv = a_rv; a_pr = a_rdy; a_pw = a_rw; a_pa = a_raddr; a_pd = a_wdata;
  end

  // memory responder and monitor for B
  always @(negedge clk) begin
    pend_t p;
    req_t  r;
    aw_t   w;
    b_rdy = rnd[1] ? 1'($urandom_range(0, 1)) : 1'b1;
    if (b_rv && !b_rw && (acc[1] - rets[1]) >= 2) bad[1]++;
    if (b_rv && b_rdy) begin
      r.w = b_rw; r.addr = b_raddr; r.data = b_wdata;
      b_reqs.push_back(r);
      if (!b_rw) begin
        p.addr = b_raddr;
        p.due  = cyc + (rdly[1] ? int'($urandom_range(0, 4)) : dly[1]);
        b_pend.push_back(p);
        acc[1]++;
      end
    end
    if (b_pend.size() > 0 && b_pend[0].due <= cyc) begin
      b_dv = 1'b1;
      b_rdata = memf(b_pend[0].addr);
      void'(b_pend.pop_front());
      rets[1]++;
    end else begin
      b_dv = 1'b0;
      b_rdata = '0;
    end
    #1;
    if (b_wda) begin
      w.idx = int'(b_aidx); w.data = b_adata;
      b_aws.push_back(w);
    end
    if (b_done) begin
      dones[1]++;
      done_cyc[1] = cyc;
      if (!(b_wda && b_aidx == 2'd3 && b_busy)) bad[1]++;
    end
    tags[1] += int'(b_tag);
    vbs[1]  += int'(b_vb);
    cds[1]  += int'(b_cd);
    if (b_pv && !b_pr && !(b_rv && b_raddr == b_pa)) bad[1]++;
    b_pv = b_rv; b_pr = b_rdy; b_pa = b_raddr;
  end

  task automatic clr(input int n);
    if (n == 0) begin
      a_reqs.delete(); a_aws.delete();
    end else begin
      b_reqs.delete(); b_aws.delete();
    end
    acc[n] = 0; rets[n] = 0; dones[n] = 0; tags[n] = 0;
    vbs[n] = 0; cds[n] = 0; bad[n] = 0;
  endtask

  task automatic miss(input int n, input logic [31:0] m, input logic [31:0] v,
                      input bit d, output int c0);
    @(negedge clk); #2;
    c0 = cyc;
    if (n == 0) begin
      a_miss = 1'b1; a_maddr = m[15:0]; a_vaddr = v[15:0]; a_vd = d;
    end else begin
      b_miss = 1'b1; b_maddr = m; b_vaddr = v; b_vd = d;
    end
    @(negedge clk); #2;
    a_miss = 1'b0;
    b_miss = 1'b0;
  endtask

  task automatic wait_done(input int n, input string nm);
    for (int c = 0; c < 600 && dones[n] == 0; c++) begin
      @(negedge clk); #2;
    end
    chk({nm, "_done_seen"}, dones[n] > 0, 1);
    repeat (3) @(negedge clk);
    #2;
    chk({nm, "_idle"}, (n == 0) ? a_busy : b_busy, 0);
  endtask

  // Expected traffic: optional writeback of the whole victim line in word
  // order, then reads of the whole miss line; array gets returned words in order.
  task automatic verify(input string nm, input req_t rq[$], input aw_t wq[$],
                        input int n, input logic [31:0] maddr,
                        input logic [31:0] vaddr, input bit wb,
                        input int words, input int bytes,
                        input logic [31:0] m);
    logic [31:0] line, mb, vb;
    req_t ex[$];
    req_t e;
    line = 32'(words * bytes);
    mb = maddr - (maddr % line);
    vb = vaddr - (vaddr % line);
    if (wb) begin
      for (int i = 0; i < words; i++) begin
        e.w = 1'b1; e.addr = (vb + 32'(i * bytes)) & m; e.data = a_arr[i] & m;
        ex.push_back(e);
      end
    end
    for (int i = 0; i < words; i++) begin
      e.w = 1'b0; e.addr = (mb + 32'(i * bytes)) & m; e.data = '0;
      ex.push_back(e);
    end
    chk({nm, "_nreq"}, rq.size(), ex.size());
    for (int i = 0; i < ex.size() && i < rq.size(); i++) begin
      chk({nm, "_rw"}, rq[i].w, ex[i].w);
      chk({nm, "_addr"}, rq[i].addr, ex[i].addr);
      if (ex[i].w) chk({nm, "_wdata"}, rq[i].data, ex[i].data);
    end
    chk({nm, "_nfill"}, wq.size(), words);
    for (int i = 0; i < words && i < wq.size(); i++) begin
      chk({nm, "_fidx"}, wq[i].idx, i);
      chk({nm, "_fdata"}, wq[i].data, memf((mb + 32'(i * bytes)) & m) & m);
    end
    chk({nm, "_done"}, dones[n], 1);
    chk({nm, "_tag"}, tags[n], 1);
    chk({nm, "_valid"}, vbs[n], 1);
    chk({nm, "_clrdirty"}, cds[n], 1);
    chk({nm, "_protocol"}, bad[n], 0);
  endtask

  task automatic run(input int n, input logic [31:0] m, input logic [31:0] v,
                     input bit d, input string nm);
    clr(n);
    miss(n, m, v, d, last_c0);
    wait_done(n, nm);
    if (n == 0) verify(nm, a_reqs, a_aws, 0, m, v, d, 8, 2, 32'h0000FFFF);
    else verify(nm, b_reqs, b_aws, 1, m, v, 1'b0, 4, 4, 32'hFFFFFFFF);
  endtask

  initial begin
    seed = $urandom;
    rst_n = 1'b0;
    a_miss = 1'b0; a_vd = 1'b0; a_maddr = '0; a_vaddr = '0;
    b_miss = 1'b0; b_vd = 1'b0; b_maddr = '0; b_vaddr = '0;
    a_rdy = 1'b0; a_dv = 1'b0; a_rdata = '0;
    b_rdy = 1'b0; b_dv = 1'b0; b_rdata = '0;
    a_pv = 1'b0; a_pr = 1'b0; a_pw = 1'b0; a_pa = '0; a_pd = '0;
    b_pv = 1'b0; b_pr = 1'b0; b_pa = '0;
    b_rdat = $urandom;
    for (int i = 0; i < 8; i++) a_arr[i] = $urandom;
    for (int i = 0; i < 2; i++) begin
      dly[i] = 2; rnd[i] = 1'b0; rdly[i] = 1'b0;
    end
    clr(0);
    clr(1);

    repeat (3) @(negedge clk);
    #2;
    chk("a_reset_outs", |{a_rv, a_rw, a_raddr, a_wdata, a_ridx, a_wda, a_aidx,
                          a_adata, a_tag, a_vb, a_cd, a_busy, a_done}, 0);
    chk("b_reset_outs", |{b_rv, b_rw, b_raddr, b_wdata, b_ridx, b_wda, b_aidx,
                          b_adata, b_tag, b_vb, b_cd, b_busy, b_done}, 0);
    rst_n = 1'b1;

    dly[0] = 2;
    run(0, 32'h1234, 32'h0000, 1'b0, "clean");

    for (int i = 0; i < 8; i++) a_arr[i] = 32'hA0 + 32'(i);
    run(0, 32'h9A00, 32'h5670, 1'b1, "dirty");

    dly[0] = 0;
    run(0, 32'h00F6, 32'h1000, 1'b0, "minlat");
    chk("minlat_cycles", done_cyc[0] - last_c0, 8);

    dly[0] = 6;
    run(0, 32'hBEEF, 32'h3030, 1'b1, "slow_a");
    dly[1] = 6;
    run(1, 32'h0000FFF8, 32'h00008000, 1'b1, "slow_b");

    rnd[0] = 1'b1; rdly[0] = 1'b1;
    rnd[1] = 1'b1; rdly[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) a_arr[i] = $urandom;
      run(0, $urandom, $urandom, k != 1, "rand_a");
      run(1, $urandom, $urandom, 1'b1, "rand_b");
    end
    rnd[0] = 1'b0; rdly[0] = 1'b0;
    rnd[1] = 1'b0; rdly[1] = 1'b0;

    dly[0] = 2;
    clr(0);
    miss(0, 32'h4444, 32'h0000, 1'b0, last_c0);
    for (int c = 0; c < 100 && a_aws.size() < 3; c++) begin
      @(negedge clk); #2;
    end
    chk("abort_ret3", a_aws.size() >= 3, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", |{a_rv, a_rw, a_raddr, a_wdata, a_ridx, a_wda, a_aidx,
                        a_adata, a_tag, a_vb, a_cd, a_busy, a_done}, 0);
    a_pend.delete();
    repeat (2) @(negedge clk);
    #2;
    chk("abort_notag", tags[0] + vbs[0] + dones[0], 0);
    rst_n = 1'b1;
    run(0, 32'h7777, 32'h0000, 1'b0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
